ahb_mtx_in_hold: RTL and testbench
==================================

AHB_MTX_IN_HOLD -- requirements
Module: ahb_mtx_in_hold

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 HCLK  in  1  system clock; single clock domain.
REQ-003 HRESET  in  1  reset, synchronous and active-high.
REQ-004 HSELS  in  1  master-side slave select.
REQ-005 HADDRS  in  ADDR_W  master address.
REQ-006 HTRANSS  in  2  master transfer type.
REQ-007 HCTRLS  in  11  master attributes {HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0]}; packing is defined in the package.
REQ-008 HMASTLOCKS  in  1  master lock.
REQ-009 HREADYS  in  1  bus-level HREADY seen by the master.
REQ-010 HREADYOUTS  out  1  ready returned to the master.
REQ-011 HRESPS  out  1  response returned to the master.
REQ-012 sel_o, addr_o, trans_o, ctrl_o, mastlock_o  out  1/ADDR_W/2/11/1  address phase presented to the output arbiters.
REQ-013 req_o  out  1  request to the output arbiters.
REQ-014 grant_i  in  1  the output stage accepts this port's address phase this cycle.
REQ-015 data_phase_i  in  1  this port owns an active data phase at a slave.
REQ-016 HREADYM_i  in  1  slave HREADYOUT routed back to this port.
REQ-017 HRESPM_i  in  1  slave HRESP routed back to this port.

Function
REQ-018 The block SHALL have two states: PASS (outputs follow the master inputs combinationally) and HOLD (outputs are driven from the hold register).
REQ-019 Capture condition: PASS & HSELS & HREADYS & HTRANSS[1] & ~grant_i.
- On capture, the block SHALL load addr, trans, ctrl and lock into the hold register.
- On capture, the block SHALL enter HOLD on the next edge.
REQ-020 In PASS, req_o SHALL equal HSELS & HTRANSS[1]; PASS SHALL be granted in the same cycle with zero added latency.
REQ-021 In HOLD, req_o and sel_o SHALL be 1. HOLD SHALL move to PASS on the edge where grant_i & HREADYM_i.
REQ-022 HREADYOUTS SHALL follow these rules:
- HOLD: 0.
- PASS with data_phase_i: HREADYM_i.
- Otherwise: 1.
REQ-023 HRESPS SHALL equal HRESPM_i when data_phase_i, else 0 (OKAY).
REQ-024 The hold register SHALL NOT change while in HOLD; the master stalls because HREADYOUTS=0.
REQ-025 In HOLD, the held trans SHALL be presented unchanged, including SEQ.
REQ-026 When grant_i and capture occur in the same cycle, grant SHALL win: no capture, state stays PASS.
REQ-027 IDLE/BUSY transfers and HSELS=0 SHALL never cause a capture or assert req_o.
REQ-028 Back-to-back behaviour: exiting HOLD to PASS, the next master transfer SHALL be evaluated by REQ-019 in that same PASS cycle.

Reset
REQ-029 When HRESET=1 at a HCLK edge:
- state SHALL go to PASS.
- The hold register SHALL clear to 0, giving trans_o=IDLE.
- req_o and mastlock_o SHALL be 0.
- HREADYOUTS SHALL be 1.
REQ-030 A reset while in HOLD SHALL discard the held transfer; no request is emitted afterwards.

Configuration
REQ-031 Macro AHB_MTX_IN_HOLD_LOCK_EN.
- Defined: mastlock_o SHALL carry HMASTLOCKS in PASS and the held lock in HOLD.
- Defined: req_o SHALL stay 1 in PASS while HMASTLOCKS=1, even for IDLE transfers.
- Undefined: mastlock_o SHALL be tied 0, the lock register SHALL be omitted, and HMASTLOCKS SHALL be ignored.

Structure
REQ-032 The shared package ahb_mtx_pkg SHALL hold:
- HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
- The HCTRL field offsets and width 11.
- The state enumeration PASS/HOLD.
REQ-033 A single sub-module ahb_mtx_in_hold_reg SHALL hold the capture register (address, trans, ctrl, lock); the top level contains the FSM and the muxing.

Verification
REQ-034 Scenario: NONSEQ to 0x2000_0010 with grant_i=1 in the same cycle -> no HOLD; req_o=1 for that cycle only; HREADYOUTS=1.
REQ-035 Scenario: NONSEQ to 0x4000_0000 with grant_i=0 for 3 cycles, then grant_i=1 and HREADYM_i=1 -> HOLD for 3 cycles; addr_o=0x4000_0000 throughout; HREADYOUTS=0 for 3 cycles, then PASS.
REQ-036 Scenario: HOLD active and a new NONSEQ driven on the master pins -> addr_o and ctrl_o keep the held values until grant.
REQ-037 Scenario: HRESET=1 asserted in the second HOLD cycle -> on the next edge, req_o=0, trans_o=0, HREADYOUTS=1; no late grant consumption.
REQ-038 Scenario: data_phase_i=1, HREADYM_i=0 then 1, HRESPM_i=1 -> HREADYOUTS is 0 then 1 and HRESPS=1, mirroring the slave.
REQ-039 Scenario: with AHB_MTX_IN_HOLD_LOCK_EN, locked NONSEQ then IDLE -> mastlock_o=1 and req_o=1 across both cycles; without the macro, mastlock_o=0.

Source files
------------

// File: rtl/ahb_mtx_pkg.sv
// Shared definitions for the AHB matrix input stage: HTRANS encodings,
// HCTRL field packing {HWRITE, HSIZE, HBURST, HPROT} and hold FSM states.
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HCTRL packing, LSB first: HPROT[3:0], HBURST[2:0], HSIZE[2:0], HWRITE
    localparam int HPROT_LSB  = 0;
    localparam int HPROT_W    = 4;
    localparam int HBURST_LSB = HPROT_LSB + HPROT_W;
    localparam int HBURST_W   = 3;
    localparam int HSIZE_LSB  = HBURST_LSB + HBURST_W;
    localparam int HSIZE_W    = 3;
    localparam int HWRITE_BIT = HSIZE_LSB + HSIZE_W;
    localparam int HCTRL_W    = HWRITE_BIT + 1;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_e;

    // True for transfer types that need a slave address phase
    function automatic logic is_xfer(input logic [1:0] t);
        logic r;
        r = 1'b0;
        case (t)
            HTRANS_IDLE, HTRANS_BUSY: r = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_mtx_in_hold_reg.sv
// Capture register for a stalled master address phase.
// Ports: HCLK/HRESET, load strobe, *_d captured values, *_q held values.
// Lock bit present only with AHB_MTX_IN_HOLD_LOCK_EN.
module ahb_mtx_in_hold_reg
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               load,
    input  logic [ADDR_W-1:0]  addr_d,
    input  logic [1:0]         trans_d,
    input  logic [HCTRL_W-1:0] ctrl_d,
`ifdef AHB_MTX_IN_HOLD_LOCK_EN
    input  logic               lock_d,
    output logic               lock_q,
`endif
    output logic [ADDR_W-1:0]  addr_q,
    output logic [1:0]         trans_q,
    output logic [HCTRL_W-1:0] ctrl_q
);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q  <= '0;
            trans_q <= HTRANS_IDLE;
            ctrl_q  <= '0;
        end else if (load) begin
            addr_q  <= addr_d;
            trans_q <= trans_d;
            ctrl_q  <= ctrl_d;
        end
    end

`ifdef AHB_MTX_IN_HOLD_LOCK_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lock_q <= 1'b0;
        end else if (load) begin
            lock_q <= lock_d;
        end
    end
`endif

endmodule

// File: rtl/ahb_mtx_in_hold.sv
// AHB matrix input stage: passes the master address phase straight to the
// output arbiters, or holds it and stalls the master when not granted.
// Ports: master side H*S, arbiter side *_o/grant_i, slave return
// data_phase_i/HREADYM_i/HRESPM_i. Option macro: AHB_MTX_IN_HOLD_LOCK_EN.
module ahb_mtx_in_hold
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSELS,
    input  logic [ADDR_W-1:0]  HADDRS,
    input  logic [1:0]         HTRANSS,
    input  logic [HCTRL_W-1:0] HCTRLS,
    input  logic               HMASTLOCKS,
    input  logic               HREADYS,
    output logic               HREADYOUTS,
    output logic               HRESPS,
    output logic               sel_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [1:0]         trans_o,
    output logic [HCTRL_W-1:0] ctrl_o,
    output logic               mastlock_o,
    output logic               req_o,
    input  logic               grant_i,
    input  logic               data_phase_i,
    input  logic               HREADYM_i,
    input  logic               HRESPM_i
);

    hold_state_e state_q;
    hold_state_e state_d;

    logic               capture;
    logic [ADDR_W-1:0]  h_addr;
    logic [1:0]         h_trans;
    logic [HCTRL_W-1:0] h_ctrl;
    logic               h_lock;
    logic               lock_in;

    // A same-cycle grant means the address phase is already taken
    assign capture = (state_q == ST_PASS) & HSELS & HREADYS &
                     is_xfer(HTRANSS) & ~grant_i;

    ahb_mtx_in_hold_reg #(
        .ADDR_W (ADDR_W)
    ) u_reg (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .load    (capture),
        .addr_d  (HADDRS),
        .trans_d (HTRANSS),
        .ctrl_d  (HCTRLS),
`ifdef AHB_MTX_IN_HOLD_LOCK_EN
        .lock_d  (HMASTLOCKS),
        .lock_q  (h_lock),
`endif
        .addr_q  (h_addr),
        .trans_q (h_trans),
        .ctrl_q  (h_ctrl)
    );

`ifdef AHB_MTX_IN_HOLD_LOCK_EN
    assign lock_in = HMASTLOCKS;
`else
    logic unused_lock;
    assign unused_lock = HMASTLOCKS;
    assign lock_in     = 1'b0;
    assign h_lock      = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PASS: if (capture) state_d = ST_HOLD;
            ST_HOLD: if (grant_i & HREADYM_i) state_d = ST_PASS;
            default: state_d = ST_PASS;
        endcase
    end

    always_comb begin
        sel_o      = HSELS;
        addr_o     = HADDRS;
        trans_o    = HTRANSS;
        ctrl_o     = HCTRLS;
        mastlock_o = lock_in;
        // A locked master keeps its request up across IDLE cycles
        req_o      = HSELS & (is_xfer(HTRANSS) | lock_in);
        HREADYOUTS = data_phase_i ? HREADYM_i : 1'b1;
        unique case (state_q)
            ST_PASS: ;
            ST_HOLD: begin
                sel_o      = 1'b1;
                addr_o     = h_addr;
                trans_o    = h_trans;
                ctrl_o     = h_ctrl;
                mastlock_o = h_lock;
                req_o      = 1'b1;
                HREADYOUTS = 1'b0;
            end
            default: ;
        endcase
    end

    assign HRESPS = data_phase_i ? HRESPM_i : 1'b0;

endmodule

// File: tb/tb_ahb_mtx_in_hold.sv
// Directed scoreboard bench for ahb_mtx_in_hold: stimulus pushes expected
// outputs, a negedge monitor pops and compares.
module tb_ahb_mtx_in_hold;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NS   = 2'b10;
    localparam logic [1:0] SQ   = 2'b11;
    localparam logic [10:0] C1  = 11'h4A3;
    localparam logic [10:0] C2  = 11'h215;
    localparam logic [10:0] C3  = 11'h7FF;
`ifdef AHB_MTX_IN_HOLD_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSELS = 1'b0;
    logic [31:0] HADDRS = '0;
    logic [1:0]  HTRANSS = IDLE;
    logic [10:0] HCTRLS = '0;
    logic        HMASTLOCKS = 1'b0;
    logic        HREADYS = 1'b1;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        sel_o;
    logic [31:0] addr_o;
    logic [1:0]  trans_o;
    logic [10:0] ctrl_o;
    logic        mastlock_o;
    logic        req_o;
    logic        grant_i = 1'b0;
    logic        data_phase_i = 1'b0;
    logic        HREADYM_i = 1'b0;
    logic        HRESPM_i = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_mtx_in_hold #(.ADDR_W(32)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HSELS        (HSELS),
        .HADDRS       (HADDRS),
        .HTRANSS      (HTRANSS),
        .HCTRLS       (HCTRLS),
        .HMASTLOCKS   (HMASTLOCKS),
        .HREADYS      (HREADYS),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .sel_o        (sel_o),
        .addr_o       (addr_o),
        .trans_o      (trans_o),
        .ctrl_o       (ctrl_o),
        .mastlock_o   (mastlock_o),
        .req_o        (req_o),
        .grant_i      (grant_i),
        .data_phase_i (data_phase_i),
        .HREADYM_i    (HREADYM_i),
        .HRESPM_i     (HRESPM_i)
    );

    typedef struct {
        string       name;
        logic        req;
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [10:0] ctrl;
        logic        lock;
        logic        hrdy;
        logic        hresp;
    } exp_t;

    exp_t exp_q[$];
    int   applied = 0;
    int   miscompares = 0;

    task automatic step(
        input string nm, input bit rst, input bit sel, input logic [31:0] a,
        input logic [1:0] t, input logic [10:0] c, input bit lk, input bit hrs,
        input bit g, input bit dp, input bit hrm, input bit hrp,
        input bit er, input bit es, input logic [31:0] ea, input logic [1:0] et,
        input logic [10:0] ec, input bit el, input bit eh, input bit ep);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESET = rst;
        HSELS = sel;
        HADDRS = a;
        HTRANSS = t;
        HCTRLS = c;
        HMASTLOCKS = lk;
        HREADYS = hrs;
        grant_i = g;
        data_phase_i = dp;
        HREADYM_i = hrm;
        HRESPM_i = hrp;
        e.name = nm;
        e.req = er;
        e.sel = es;
        e.addr = ea;
        e.trans = et;
        e.ctrl = ec;
        e.lock = el;
        e.hrdy = eh;
        e.hresp = ep;
        exp_q.push_back(e);
    endtask

    always @(negedge HCLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            applied++;
            if (req_o !== e.req || sel_o !== e.sel || addr_o !== e.addr ||
                trans_o !== e.trans || ctrl_o !== e.ctrl ||
                mastlock_o !== e.lock || HREADYOUTS !== e.hrdy ||
                HRESPS !== e.hresp) begin
                miscompares++;
                $display("FAIL %s: got req=%b sel=%b addr=%h trans=%b ctrl=%h lock=%b rdy=%b resp=%b, want req=%b sel=%b addr=%h trans=%b ctrl=%h lock=%b rdy=%b resp=%b",
                         e.name, req_o, sel_o, addr_o, trans_o, ctrl_o,
                         mastlock_o, HREADYOUTS, HRESPS, e.req, e.sel,
                         e.addr, e.trans, e.ctrl, e.lock, e.hrdy, e.hresp);
            end
        end
    end

    initial begin
        //   name         rst sel addr          trans ctrl lk hrs g dp hrm hrp | req sel addr         trans ctrl lock rdy resp
        step("rst0",        1, 0, 32'h0,        IDLE, 0,  0, 1, 0, 0, 0, 0,  0, 0, 32'h0,        IDLE, 0,  0,  1, 0);
        step("rst1",        1, 0, 32'h0,        IDLE, 0,  0, 1, 0, 0, 0, 0,  0, 0, 32'h0,        IDLE, 0,  0,  1, 0);
        step("ns_granted",  0, 1, 32'h2000_0010, NS,  C1, 0, 1, 1, 0, 0, 0,  1, 1, 32'h2000_0010, NS,  C1, 0,  1, 0);
        step("idle_after",  0, 0, 32'h0,        IDLE, 0,  0, 1, 0, 0, 0, 0,  0, 0, 32'h0,        IDLE, 0,  0,  1, 0);
        step("capture",     0, 1, 32'h4000_0000, NS,  C2, 0, 1, 0, 0, 0, 0,  1, 1, 32'h4000_0000, NS,  C2, 0,  1, 0);
        step("hold1_new",   0, 1, 32'h5000_0000, NS,  C3, 0, 1, 0, 0, 0, 0,  1, 1, 32'h4000_0000, NS,  C2, 0,  0, 0);
        step("hold2",       0, 0, 32'h0,        IDLE, 0,  0, 1, 0, 0, 0, 0,  1, 1, 32'h4000_0000, NS,  C2, 0,  0, 0);
        step("hold3_grant", 0, 1, 32'h5000_0000, NS,  C3, 0, 1, 1, 0, 1, 0,  1, 1, 32'h4000_0000, NS,  C2, 0,  0, 0);
        step("b2b_capture", 0, 1, 32'h6000_0004, NS,  C3, 0, 1, 0, 0, 0, 0,  1, 1, 32'h6000_0004, NS,  C3, 0,  1, 0);
        step("hold_nordy",  0, 0, 32'h0,        IDLE, 0,  0, 1, 1, 1, 0, 1,  1, 1, 32'h6000_0004, NS,  C3, 0,  0, 1);
        step("rst_in_hold", 1, 0, 32'h0,        IDLE, 0,  0, 1, 1, 0, 1, 0,  1, 1, 32'h6000_0004, NS,  C3, 0,  0, 0);
        step("post_rst",    0, 0, 32'h0,        IDLE, 0,  0, 1, 1, 0, 1, 0,  0, 0, 32'h0,        IDLE, 0,  0,  1, 0);
        step("seq_capture", 0, 1, 32'h7000_0008, SQ,  C1, 0, 1, 0, 0, 0, 0,  1, 1, 32'h7000_0008, SQ,  C1, 0,  1, 0);
        step("seq_held",    0, 0, 32'h0,        IDLE, 0,  0, 1, 1, 0, 1, 0,  1, 1, 32'h7000_0008, SQ,  C1, 0,  0, 0);
        step("busy",        0, 1, 32'h7000_000C, BUSY, C1, 0, 1, 0, 0, 0, 0,  0, 1, 32'h7000_000C, BUSY, C1, 0,  1, 0);
        step("unselected",  0, 0, 32'h8000_0000, NS,  C2, 0, 1, 0, 0, 0, 0,  0, 0, 32'h8000_0000, NS,  C2, 0,  1, 0);
        step("hreadys_low", 0, 1, 32'h9000_0000, NS,  C2, 0, 0, 0, 0, 0, 0,  1, 1, 32'h9000_0000, NS,  C2, 0,  1, 0);
        step("still_pass",  0, 0, 32'h0,        IDLE, 0,  0, 1, 0, 0, 0, 0,  0, 0, 32'h0,        IDLE, 0,  0,  1, 0);
        step("dp_wait",     0, 0, 32'h0,        IDLE, 0,  0, 1, 0, 1, 0, 1,  0, 0, 32'h0,        IDLE, 0,  0,  0, 1);
        step("dp_done",     0, 0, 32'h0,        IDLE, 0,  0, 1, 0, 1, 1, 1,  0, 0, 32'h0,        IDLE, 0,  0,  1, 1);
        step("dp_off",      0, 0, 32'h0,        IDLE, 0,  0, 1, 0, 0, 0, 1,  0, 0, 32'h0,        IDLE, 0,  0,  1, 0);
        step("lock_ns",     0, 1, 32'hA000_0000, NS,  C2, 1, 1, 1, 0, 0, 0,  1, 1, 32'hA000_0000, NS,  C2, LK, 1, 0);
        step("lock_idle",   0, 1, 32'hA000_0000, IDLE, C2, 1, 1, 1, 0, 0, 0, LK, 1, 32'hA000_0000, IDLE, C2, LK, 1, 0);
        step("unlock",      0, 1, 32'hA000_0000, IDLE, C2, 0, 1, 1, 0, 0, 0,  0, 1, 32'hA000_0000, IDLE, C2, 0,  1, 0);
        step("lock_capt",   0, 1, 32'hB000_0000, NS,  C1, 1, 1, 0, 0, 0, 0,  1, 1, 32'hB000_0000, NS,  C1, LK, 1, 0);
        step("lock_held",   0, 0, 32'h0,        IDLE, 0,  0, 1, 1, 0, 1, 0,  1, 1, 32'hB000_0000, NS,  C1, LK, 0, 0);
        step("final_idle",  0, 0, 32'h0,        IDLE, 0,  0, 1, 0, 0, 0, 0,  0, 0, 32'h0,        IDLE, 0,  0,  1, 0);
        repeat (2) @(posedge HCLK);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
